// File: rtl/pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
package pipe_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Pipeline-register control bundle, one bit per stall/flush line
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_NONE  = 7'b000_0000;
  localparam hz_ctrl_t CTRL_RESET = 7'b000_0111;
  localparam hz_ctrl_t CTRL_MEM   = 7'b111_1001;
  localparam hz_ctrl_t CTRL_HOLD  = 7'b110_0010;

endpackage

// File: rtl/fwd_unit.sv
// EX-stage operand forwarding select; MEM result wins over WB, $0 is never forwarded.
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic [REG_W-1:0] WriteRegW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE
);

  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic [REG_W-1:0] dst_m,
    input logic [REG_W-1:0] dst_w,
    input logic             we_m,
    input logic             we_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (we_m && (dst_m != '0) && (dst_m == src)) begin
      sel = FWD_MEM;
    end else if (we_w && (dst_w != '0) && (dst_w == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    ForwardAE = fwd_sel(RsE, WriteRegM, WriteRegW, RegWriteM, RegWriteW);
    ForwardBE = fwd_sel(RtE, WriteRegM, WriteRegW, RegWriteM, RegWriteW);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: stall/flush lines, forwarding selects,
// load-use / branch / memory-wait / halt-drain FSM and saturating event counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] WriteRegE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic [REG_W-1:0] WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             BranchTakenE,
  input  logic             JumpD,
  input  logic             HaltD,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             Done,
  output logic             ErrTimeout,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int unsigned DRN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam int unsigned TMO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [1:0]       stall_inc, flush_inc;
  logic             done_set, err_set;
  logic             lu, mem_wait;
  hz_ctrl_t         ctrl;

  fwd_unit u_fwd (
    .RsE       (RsE),
    .RtE       (RtE),
    .WriteRegM (WriteRegM),
    .WriteRegW (WriteRegW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE)
  );

  assign lu = MemtoRegE && RegWriteE && (WriteRegE != '0) &&
              ((WriteRegE == RsD) || (WriteRegE == RtD));
  assign mem_wait = MemReqM && !MemReadyM;

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] cnt,
    input logic [1:0]       inc
  );
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(cnt) + SUM_W'(inc);
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  // Next state and same-cycle control lines
  always_comb begin
    ctrl      = CTRL_NONE;
    state_d   = state_q;
    drn_d     = drn_q;
    tmo_d     = tmo_q;
    stall_inc = 2'd0;
    flush_inc = 2'd0;
    done_set  = 1'b0;
    err_set   = 1'b0;

    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_wait) begin
          ctrl      = CTRL_MEM;
          stall_inc = 2'd1;
          if (state_q == ST_RUN) begin
            state_d = ST_MEM_WAIT;
            tmo_d   = '0;
          end else if (tmo_q == TMO_LAST) begin
            err_set = 1'b1;
            state_d = ST_RUN;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end else begin
          // Release cycle of a memory wait is evaluated like RUN so a held branch is honoured
          state_d = ST_RUN;
          tmo_d   = '0;
          if (BranchTakenE) begin
            ctrl.flush_d = 1'b1;
            ctrl.flush_e = 1'b1;
            flush_inc    = 2'd2;
          end else if (lu) begin
            ctrl.stall_f = 1'b1;
            ctrl.stall_d = 1'b1;
            ctrl.flush_e = 1'b1;
            stall_inc    = 2'd1;
          end else if (JumpD) begin
            ctrl.flush_d = 1'b1;
            flush_inc    = 2'd1;
          end else if (HaltD) begin
            ctrl.stall_f = 1'b1;
            ctrl.flush_d = 1'b1;
            drn_d        = DRN_LOAD;
            state_d      = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (mem_wait) begin
          ctrl      = CTRL_MEM;
          stall_inc = 2'd1;
        end else begin
          ctrl = CTRL_HOLD;
          if (drn_q <= DRN_W'(1)) begin
            drn_d    = '0;
            state_d  = ST_DONE;
            done_set = 1'b1;
          end else begin
            drn_d = drn_q - DRN_W'(1);
          end
        end
      end

      ST_DONE: begin
        ctrl = CTRL_HOLD;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (RESET) begin
      ctrl = CTRL_RESET;
    end
  end

  assign StallF = ctrl.stall_f;
  assign StallD = ctrl.stall_d;
  assign StallE = ctrl.stall_e;
  assign StallM = ctrl.stall_m;
  assign FlushD = ctrl.flush_d;
  assign FlushE = ctrl.flush_e;
  assign FlushW = ctrl.flush_w;

  // State, sequencing counters, sticky flags and event counters
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_RUN;
      drn_q      <= '0;
      tmo_q      <= '0;
      StallCount <= '0;
      FlushCount <= '0;
      Done       <= 1'b0;
      ErrTimeout <= 1'b0;
    end else begin
      state_q    <= state_d;
      drn_q      <= drn_d;
      tmo_q      <= tmo_d;
      StallCount <= sat_add(StallCount, stall_inc);
      FlushCount <= sat_add(FlushCount, flush_inc);
      Done       <= Done | done_set;
      ErrTimeout <= ErrTimeout | err_set;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expectations, a negedge monitor checks them.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int unsigned CNT_W = 32;

  localparam logic [6:0] C_NONE = 7'b000_0000;
  localparam logic [6:0] C_RST  = 7'b000_0111;
  localparam logic [6:0] C_LU   = 7'b110_0010;
  localparam logic [6:0] C_BR   = 7'b000_0110;
  localparam logic [6:0] C_MEM  = 7'b111_1001;
  localparam logic [6:0] C_JMP  = 7'b000_0100;
  localparam logic [6:0] C_HALT = 7'b100_0100;
  localparam logic [6:0] C_DRN  = 7'b110_0010;

  logic CLK = 1'b0;
  logic RESET;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, JumpD, HaltD;
  logic MemReqM, MemReadyM;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic Done, ErrTimeout;
  logic [CNT_W-1:0] StallCount, FlushCount;

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl #(.DRAIN_CYCLES(4), .MEM_TIMEOUT(255), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE), .JumpD(JumpD), .HaltD(HaltD),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .Done(Done), .ErrTimeout(ErrTimeout),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  typedef enum {K_CTRL, K_FWD, K_FLAG, K_SCNT, K_FCNT} kind_e;
  typedef struct {
    string            name;
    kind_e            kind;
    logic [6:0]       ctrl;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] ctrl_act;
  assign ctrl_act = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  // Monitor: every expectation queued for this cycle is compared at the falling edge
  always @(negedge CLK) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      case (e.kind)
        K_CTRL: if (ctrl_act !== e.ctrl) begin
          errors++;
          $display("FAIL %s: ctrl {SF,SD,SE,SM,FD,FE,FW} act=%b req=%b", e.name, ctrl_act, e.ctrl);
        end
        K_FWD: if ({ForwardAE, ForwardBE} !== {e.fa, e.fb}) begin
          errors++;
          $display("FAIL %s: fwd A/B act=%b/%b req=%b/%b", e.name, ForwardAE, ForwardBE, e.fa, e.fb);
        end
        K_FLAG: if ({Done, ErrTimeout} !== {e.done, e.err}) begin
          errors++;
          $display("FAIL %s: Done/ErrTimeout act=%b/%b req=%b/%b", e.name, Done, ErrTimeout, e.done, e.err);
        end
        K_SCNT: if (StallCount !== e.cnt) begin
          errors++;
          $display("FAIL %s: StallCount act=%0d req=%0d", e.name, StallCount, e.cnt);
        end
        default: if (FlushCount !== e.cnt) begin
          errors++;
          $display("FAIL %s: FlushCount act=%0d req=%0d", e.name, FlushCount, e.cnt);
        end
      endcase
    end
  end

  task automatic exp_ctrl(input string n, input logic [6:0] c);
    exp_t e;
    e.name = n; e.kind = K_CTRL; e.ctrl = c;
    sb.push_back(e);
  endtask

  task automatic exp_fwd(input string n, input logic [1:0] a, input logic [1:0] b);
    exp_t e;
    e.name = n; e.kind = K_FWD; e.fa = a; e.fb = b;
    sb.push_back(e);
  endtask

  task automatic exp_flag(input string n, input logic d, input logic er);
    exp_t e;
    e.name = n; e.kind = K_FLAG; e.done = d; e.err = er;
    sb.push_back(e);
  endtask

  task automatic exp_sc(input string n, input logic [CNT_W-1:0] v);
    exp_t e;
    e.name = n; e.kind = K_SCNT; e.cnt = v;
    sb.push_back(e);
  endtask

  task automatic exp_fc(input string n, input logic [CNT_W-1:0] v);
    exp_t e;
    e.name = n; e.kind = K_FCNT; e.cnt = v;
    sb.push_back(e);
  endtask

  task automatic idle();
    RsD = '0; RtD = '0; RsE = '0; RtE = '0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemtoRegE = 1'b0; BranchTakenE = 1'b0; JumpD = 1'b0; HaltD = 1'b0;
    MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    idle();
    tick();
    exp_ctrl("reset_flush", C_RST); tick();
    RESET = 1'b0;
    exp_ctrl("run_idle", C_NONE);
    exp_fwd("reset_fwd", FWD_RF, FWD_RF);
    exp_sc("reset_scnt", 0);
    exp_fc("reset_fcnt", 0);
    exp_flag("reset_flags", 1'b0, 1'b0);
    tick();

    // Load-use: lw $2 in EX, consumer of $2 in ID
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd2; RsD = 5'd2; RtD = 5'd3;
    exp_ctrl("lu_bubble", C_LU); tick();
    idle(); RegWriteM = 1'b1; WriteRegM = 5'd2; RsD = 5'd2; RtD = 5'd3;
    exp_ctrl("lu_single_cycle", C_NONE); exp_sc("lu_scnt", 1); tick();
    idle(); RegWriteW = 1'b1; WriteRegW = 5'd2; RsE = 5'd2; RtE = 5'd3;
    exp_fwd("lu_fwd_wb", FWD_WB, FWD_RF); tick();

    // Forwarding priority and register 0
    idle(); RegWriteM = 1'b1; WriteRegM = 5'd5; RegWriteW = 1'b1; WriteRegW = 5'd5;
    RsE = 5'd5; RtE = 5'd5;
    exp_fwd("fwd_mem_prio", FWD_MEM, FWD_MEM); tick();
    WriteRegM = 5'd0; RsE = 5'd0;
    exp_fwd("fwd_reg0", FWD_RF, FWD_WB); tick();
    RegWriteM = 1'b0; WriteRegM = 5'd7; RsE = 5'd7; RtE = 5'd7;
    exp_fwd("fwd_no_we", FWD_RF, FWD_RF); tick();

    // Branch beats load-use, then jump
    idle(); MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd3; RtD = 5'd3; BranchTakenE = 1'b1;
    exp_ctrl("br_beats_lu", C_BR); tick();
    idle();
    exp_sc("br_scnt", 1); exp_fc("br_fcnt", 2); tick();
    JumpD = 1'b1;
    exp_ctrl("jump", C_JMP); tick();
    idle();
    exp_fc("jump_fcnt", 3); tick();

    // Memory wait, 3 cycles not ready then ready
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_ctrl("mem_wait", C_MEM); tick();
    end
    MemReadyM = 1'b1;
    exp_ctrl("mem_release", C_NONE); tick();
    idle();
    exp_ctrl("mem_back_run", C_NONE); exp_flag("mem_no_err", 1'b0, 1'b0); tick();

    // Memory wait beats branch; branch honoured on release
    MemReqM = 1'b1; BranchTakenE = 1'b1;
    exp_ctrl("mem_beats_br", C_MEM); tick();
    MemReadyM = 1'b1;
    exp_ctrl("br_on_release", C_BR); tick();
    idle();
    exp_fc("br_release_fcnt", 5); tick();

    // Memory timeout after 256 not-ready cycles
    MemReqM = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if (i == 0 || i == 255) exp_ctrl("tmo_stall", C_MEM);
      if (i == 255) exp_flag("tmo_pre", 1'b0, 1'b0);
      tick();
    end
    idle();
    exp_flag("tmo_err", 1'b0, 1'b1); exp_ctrl("tmo_back_run", C_NONE); tick();

    // Halt drain to Done, then reset from DONE
    HaltD = 1'b1;
    exp_ctrl("halt", C_HALT); tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      exp_ctrl("drain", C_DRN); exp_flag("drain_not_done", 1'b0, 1'b1); tick();
    end
    for (int i = 0; i < 3; i++) begin
      exp_ctrl("done_hold", C_DRN); exp_flag("done_sticky", 1'b1, 1'b1); tick();
    end
    RESET = 1'b1;
    exp_ctrl("reset_in_done", C_RST); tick();
    RESET = 1'b0;
    exp_ctrl("after_reset_run", C_NONE); exp_flag("after_reset_flags", 1'b0, 1'b0);
    exp_sc("after_reset_scnt", 0); exp_fc("after_reset_fcnt", 0);
    tick();

    // Reset mid-drain
    HaltD = 1'b1;
    exp_ctrl("halt2", C_HALT); tick();
    idle();
    for (int i = 0; i < 2; i++) begin
      exp_ctrl("drain2", C_DRN); tick();
    end
    RESET = 1'b1;
    exp_ctrl("reset_in_drain", C_RST); tick();
    RESET = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_ctrl("drain_reset_run", C_NONE); exp_flag("drain_reset_no_done", 1'b0, 1'b0); tick();
    end

    // Branch beats halt
    BranchTakenE = 1'b1; HaltD = 1'b1;
    exp_ctrl("br_beats_halt", C_BR); tick();
    idle();
    exp_fc("br_halt_fcnt", 2);
    for (int i = 0; i < 6; i++) begin
      exp_ctrl("br_halt_run", C_NONE); exp_flag("br_halt_no_done", 1'b0, 1'b0); tick();
    end

    tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending act=%0d req=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline.
- Drives the stall and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and the EX-stage forwarding selects.
- Runs a small FSM for load-use bubbles, taken-branch squash, data-memory wait and halt drain.
- Keeps saturating performance counters for stalls and flushes.

Parameters:
- DRAIN_CYCLES, 4: cycles from halt detection in ID to Done, letting in-flight instructions retire.
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before abort and error.
- CNT_W, 32: width of the performance counters.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- RsD, RtD  in  5  source registers of the instruction in ID
- RsE, RtE  in  5  source registers in EX
- WriteRegE, WriteRegM, WriteRegW  in  5  destination registers per stage
- RegWriteE, RegWriteM, RegWriteW  in  1  register-write enables per stage
- MemtoRegE  in  1  EX instruction is a load
- BranchTakenE  in  1  branch in EX resolved taken
- JumpD  in  1  jump decoded in ID
- HaltD  in  1  halt word (0xFFFFFFFF) decoded in ID
- MemReqM  in  1  MEM stage accessing data memory
- MemReadyM  in  1  data memory completes the access this cycle
- StallF, StallD, StallE, StallM  out  1  hold PC / IF/ID / ID/EX / EX/MEM
- FlushD, FlushE, FlushW  out  1  clear IF/ID / ID/EX / MEM/WB to a bubble (drives their RESET)
- ForwardAE, ForwardBE  out  2  00 = register file, 01 = WB result, 10 = MEM ALU result
- Done  out  1  sticky, pipeline drained after halt
- ErrTimeout  out  1  sticky, memory wait timed out
- StallCount, FlushCount  out  CNT_W  saturating event counters

Behaviour:
- Reset: RESET synchronous, active-high; clock CLK.
  - State goes to RUN.
  - Drain and timeout counters, StallCount, FlushCount, Done and ErrTimeout all go to 0.
  - In the RESET cycle: FlushD = FlushE = FlushW = 1; all Stall* = 0.
- Control outputs are combinational from state and inputs and act in the same cycle. Counters and flags are registered.
- Forwarding:
  - ForwardAE = 10 if RegWriteM and WriteRegM != 0 and WriteRegM == RsE.
  - Else 01 if RegWriteW and WriteRegW != 0 and WriteRegW == RsE.
  - Else 00.
  - ForwardBE: same rules against RtE.
  - MEM takes priority over WB.
  - Forward selects are valid in all states; register 0 is never forwarded.
- Load-use hazard (lu): MemtoRegE & RegWriteE & WriteRegE != 0 & (WriteRegE == RsD | WriteRegE == RtD).
- States:
  - RUN, priority top-down:
    - MemReqM & !MemReadyM: StallF = StallD = StallE = StallM = FlushW = 1; go to MEM_WAIT.
    - BranchTakenE: FlushD = FlushE = 1, no stall; FlushCount += 2.
    - lu: StallF = StallD = FlushE = 1 for exactly one cycle (the bubble clears lu); StallCount += 1.
    - JumpD: FlushD = 1; FlushCount += 1.
    - HaltD: StallF = 1, FlushD = 1; load drain counter with DRAIN_CYCLES; go to DRAIN.
    - Otherwise all controls are 0.
  - MEM_WAIT:
    - Same stall pattern as entry; StallCount += 1 per cycle; timeout counter increments.
    - MemReadyM = 1: release all stalls that cycle; go to RUN.
    - Timeout counter reaches MEM_TIMEOUT: set ErrTimeout; go to RUN.
  - DRAIN:
    - StallF = StallD = 1, FlushE = 1; drain counter decrements each cycle.
    - A MEM wait during DRAIN holds the drain counter; that cycle uses the MEM_WAIT stall pattern.
    - Counter reaches 0: go to DONE.
  - DONE: StallF = StallD = 1, FlushE = 1; Done = 1 until RESET.
- Simultaneous events:
  - Memory wait beats branch: the branch stays held in EX and is honoured on release.
  - Branch beats load-use: no stall; FlushE kills the consumer.
  - Branch beats halt: the halt is squashed by FlushD and the state stays RUN.
- Counters saturate at all-ones and never wrap.
- RESET in any state, including mid-MEM_WAIT or mid-DRAIN, applies reset values next edge.

Decomposition:
- Shared package pipe_pkg:
  - State encoding: RUN, MEM_WAIT, DRAIN, DONE.
  - Forward-select constants: FWD_RF, FWD_WB, FWD_MEM.
  - Halt word 32'hFFFFFFFF.
- Sub-module fwd_unit: purely combinational ForwardAE/ForwardBE logic, instantiated once.

Test Plan:
- lw $2 in EX, add using $2 in ID -> one cycle with StallF = StallD = FlushE = 1; StallCount = 1; next cycle ForwardAE = 01.
- RegWriteM = 1, WriteRegM = 5, RegWriteW = 1, WriteRegW = 5, RsE = 5 -> ForwardAE = 10. Same setup with WriteRegM = 0 and RsE = 0 -> ForwardAE = 00.
- BranchTakenE = 1 together with lu = 1 -> FlushD = FlushE = 1, StallF = 0; FlushCount = 2.
- MemReqM = 1, MemReadyM held low 3 cycles, then high -> 3 cycles of StallF..StallM = FlushW = 1, released on the 4th cycle; ErrTimeout = 0. Holding MemReadyM low for 256 cycles -> ErrTimeout = 1.
- HaltD = 1 in RUN -> DRAIN for 4 cycles, then Done = 1 and stays high; RESET after 2 DRAIN cycles -> Done stays 0 and state is RUN.
- BranchTakenE = 1 and HaltD = 1 in the same cycle -> FlushD = 1, state remains RUN, Done never set.
